// File: rtl/vector_line_stepper.sv
// ---------------------------------------------------------------------------
// vector_line_stepper
//
// Accepts line segments from the vector graphics unit and walks each one
// with Bresenham stepping. Every pixel_step pulse from the DDS serializer
// emits the current beam position as a pair of frequency words
// (X -> ch0, Y -> ch1) plus the segment brightness on both amplitude
// channels. When pixel_step arrives with no segment being drawn, a blank
// step is emitted: the amplitudes drop to zero and the frequency words hold,
// so the beam parks where it last was.
//
// Ports:
//   clk            system clock (DDS Sync_clk domain)
//   reset          synchronous, active-high reset
//   pixel_step     one-cycle pulse from the serializer: advance to next point
//   seg_valid      segment offered
//   seg_ready      segment can be accepted (high only while idle)
//   seg_x0/seg_y0  segment start point (10-bit)
//   seg_x1/seg_y1  segment end point, inclusive (10-bit)
//   seg_bright     amplitude used while drawing this segment
//   ch0frequenz    X frequency word
//   ch1frequenz    Y frequency word
//   ch0amplitude   X channel amplitude
//   ch1amplitude   Y channel amplitude
//   busy           high while a segment is being loaded or drawn
// ---------------------------------------------------------------------------
module vector_line_stepper #(
    parameter logic [31:0] FREQ_BASE  = 32'h0800_0000,
    parameter int unsigned FREQ_SHIFT = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pixel_step,
    input  logic        seg_valid,
    output logic        seg_ready,
    input  logic [9:0]  seg_x0,
    input  logic [9:0]  seg_y0,
    input  logic [9:0]  seg_x1,
    input  logic [9:0]  seg_y1,
    input  logic [9:0]  seg_bright,
    output logic [31:0] ch0frequenz,
    output logic [31:0] ch1frequenz,
    output logic [9:0]  ch0amplitude,
    output logic [9:0]  ch1amplitude,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DRAW = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Current beam position, segment end point and brightness.
    logic [9:0] xCur_q, xCur_d;
    logic [9:0] yCur_q, yCur_d;
    logic [9:0] xEnd_q, xEnd_d;
    logic [9:0] yEnd_q, yEnd_d;
    logic [9:0] bright_q, bright_d;

    // Bresenham terms. dy is kept as a negative magnitude so the classic
    // all-octant form (err = dx + dy) works without octant swapping.
    logic signed [12:0] dx_q, dx_d;
    logic signed [12:0] dy_q, dy_d;
    logic signed [12:0] err_q, err_d;
    logic               xNeg_q, xNeg_d;
    logic               yNeg_q, yNeg_d;

    // Registered outputs toward the serializer.
    logic [31:0] ch0Freq_q, ch0Freq_d;
    logic [31:0] ch1Freq_q, ch1Freq_d;
    logic [9:0]  ch0Amp_q, ch0Amp_d;
    logic [9:0]  ch1Amp_q, ch1Amp_d;

    logic               segFire;
    logic               atEnd;
    logic               stepX;
    logic               stepY;
    logic signed [12:0] xDiff;
    logic signed [12:0] yDiff;
    logic signed [12:0] e2;

    // Coordinate to DDS frequency word, wrapping modulo 2^32.
    function automatic logic [31:0] freqWord(input logic [9:0] coord);
        return FREQ_BASE + ({22'd0, coord} << FREQ_SHIFT);
    endfunction

    assign segFire = seg_valid && seg_ready;
    assign atEnd   = (xCur_q == xEnd_q) && (yCur_q == yEnd_q);

    // Signed endpoint differences; the 3 extra bits keep the full
    // 10-bit coordinate range representable with sign.
    assign xDiff = $signed({3'b000, xEnd_q}) - $signed({3'b000, xCur_q});
    assign yDiff = $signed({3'b000, yEnd_q}) - $signed({3'b000, yCur_q});

    // Both step decisions are taken from the error value before this
    // step's update, so x and y may move on the same pixel (diagonal).
    assign e2    = err_q <<< 1;
    assign stepX = (e2 >= dy_q);
    assign stepY = (e2 <= dx_q);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept in IDLE, one cycle of LOAD, then draw
    // until the end point has been emitted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (segFire) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = DRAW;
            end
            DRAW: begin
                if (pixel_step && atEnd) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake and status outputs, decoded from the state alone.
    always_comb begin
        seg_ready = (state_q == IDLE);
        busy      = (state_q != IDLE);
    end

    // Datapath next-state: segment capture, Bresenham setup, stepping,
    // and the output words presented to the serializer.
    always_comb begin
        xCur_d    = xCur_q;
        yCur_d    = yCur_q;
        xEnd_d    = xEnd_q;
        yEnd_d    = yEnd_q;
        bright_d  = bright_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        err_d     = err_q;
        xNeg_d    = xNeg_q;
        yNeg_d    = yNeg_q;
        ch0Freq_d = ch0Freq_q;
        ch1Freq_d = ch1Freq_q;
        ch0Amp_d  = ch0Amp_q;
        ch1Amp_d  = ch1Amp_q;

        case (state_q)
            IDLE: begin
                // The start point goes straight into the current position,
                // so LOAD only has to derive the stepping terms.
                if (segFire) begin
                    xCur_d   = seg_x0;
                    yCur_d   = seg_y0;
                    xEnd_d   = seg_x1;
                    yEnd_d   = seg_y1;
                    bright_d = seg_bright;
                end
            end
            LOAD: begin
                dx_d   = xDiff[12] ? -xDiff : xDiff;
                dy_d   = yDiff[12] ? yDiff : -yDiff;
                xNeg_d = !(xCur_q < xEnd_q);
                yNeg_d = !(yCur_q < yEnd_q);
                err_d  = dx_d + dy_d;
            end
            DRAW: begin
                if (pixel_step && !atEnd) begin
                    err_d = err_q + (stepX ? dy_q : 13'sd0) + (stepY ? dx_q : 13'sd0);
                    if (stepX) begin
                        xCur_d = xNeg_q ? (xCur_q - 10'd1) : (xCur_q + 10'd1);
                    end
                    if (stepY) begin
                        yCur_d = yNeg_q ? (yCur_q - 10'd1) : (yCur_q + 10'd1);
                    end
                end
            end
            default: begin
            end
        endcase

        // Outputs move only on a step. Outside DRAW a step is a blank:
        // amplitudes go dark while the frequency words keep the beam parked.
        if (pixel_step) begin
            if (state_q == DRAW) begin
                ch0Freq_d = freqWord(xCur_q);
                ch1Freq_d = freqWord(yCur_q);
                ch0Amp_d  = bright_q;
                ch1Amp_d  = bright_q;
            end else begin
                ch0Amp_d  = 10'd0;
                ch1Amp_d  = 10'd0;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            xCur_q    <= 10'd0;
            yCur_q    <= 10'd0;
            xEnd_q    <= 10'd0;
            yEnd_q    <= 10'd0;
            bright_q  <= 10'd0;
            dx_q      <= 13'sd0;
            dy_q      <= 13'sd0;
            err_q     <= 13'sd0;
            xNeg_q    <= 1'b0;
            yNeg_q    <= 1'b0;
            ch0Freq_q <= FREQ_BASE;
            ch1Freq_q <= FREQ_BASE;
            ch0Amp_q  <= 10'd0;
            ch1Amp_q  <= 10'd0;
        end else begin
            xCur_q    <= xCur_d;
            yCur_q    <= yCur_d;
            xEnd_q    <= xEnd_d;
            yEnd_q    <= yEnd_d;
            bright_q  <= bright_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            err_q     <= err_d;
            xNeg_q    <= xNeg_d;
            yNeg_q    <= yNeg_d;
            ch0Freq_q <= ch0Freq_d;
            ch1Freq_q <= ch1Freq_d;
            ch0Amp_q  <= ch0Amp_d;
            ch1Amp_q  <= ch1Amp_d;
        end
    end

    assign ch0frequenz  = ch0Freq_q;
    assign ch1frequenz  = ch1Freq_q;
    assign ch0amplitude = ch0Amp_q;
    assign ch1amplitude = ch1Amp_q;

endmodule

// File: tb/tb_vector_line_stepper.sv
// ---------------------------------------------------------------------------
// tb_vector_line_stepper
//
// Drives directed and randomized segments into vector_line_stepper and
// compares every emitted point against a reference path computed here with
// plain integer Bresenham arithmetic.
// ---------------------------------------------------------------------------
module tb_vector_line_stepper;

    localparam logic [31:0] BASE = 32'h0800_0000;

    logic        clk;
    logic        reset;
    logic        pixel_step;
    logic        seg_valid;
    logic        seg_ready;
    logic [9:0]  seg_x0;
    logic [9:0]  seg_y0;
    logic [9:0]  seg_x1;
    logic [9:0]  seg_y1;
    logic [9:0]  seg_bright;
    logic [31:0] ch0frequenz;
    logic [31:0] ch1frequenz;
    logic [9:0]  ch0amplitude;
    logic [9:0]  ch1amplitude;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;

    // Expected points of the path(s) under test.
    int expX[$];
    int expY[$];
    int expB[$];

    // Position of the last emitted point, where the beam should park.
    int lastX = 0;
    int lastY = 0;

    vector_line_stepper #(
        .FREQ_BASE  (32'h0800_0000),
        .FREQ_SHIFT (12)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pixel_step   (pixel_step),
        .seg_valid    (seg_valid),
        .seg_ready    (seg_ready),
        .seg_x0       (seg_x0),
        .seg_y0       (seg_y0),
        .seg_x1       (seg_x1),
        .seg_y1       (seg_y1),
        .seg_bright   (seg_bright),
        .ch0frequenz  (ch0frequenz),
        .ch1frequenz  (ch1frequenz),
        .ch0amplitude (ch0amplitude),
        .ch1amplitude (ch1amplitude),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frequency word for a coordinate: base plus 4096 per unit.
    function automatic logic [31:0] fw(input int c);
        return BASE + 32'(c) * 32'd4096;
    endfunction

    function automatic int clampC(input int v);
        if (v < 0) return 0;
        if (v > 1023) return 1023;
        return v;
    endfunction

    // Appends the inclusive pixel path of one segment to the expected queues.
    task automatic buildPath(input int x0, input int y0, input int x1, input int y1, input int b);
        int dx, dy, sx, sy, err, e2, x, y;
        dx  = (x1 > x0) ? (x1 - x0) : (x0 - x1);
        dy  = -((y1 > y0) ? (y1 - y0) : (y0 - y1));
        sx  = (x0 < x1) ? 1 : -1;
        sy  = (y0 < y1) ? 1 : -1;
        err = dx + dy;
        x   = x0;
        y   = y0;
        for (int n = 0; n < 4096; n++) begin
            expX.push_back(x);
            expY.push_back(y);
            expB.push_back(b);
            if (x == x1 && y == y1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin
                err = err + dy;
                x   = x + sx;
            end
            if (e2 <= dx) begin
                err = err + dx;
                y   = y + sy;
            end
        end
    endtask

    task automatic clearPath();
        expX.delete();
        expY.delete();
        expB.delete();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        pixel_step = 1'b1;
        step();
        pixel_step = 1'b0;
    endtask

    // Offers a segment and returns right after the transfer edge (in LOAD).
    // The inputs are scrambled afterwards to show they were captured.
    task automatic offerSeg(input int x0, input int y0, input int x1, input int y1, input int b);
        int n;
        seg_x0     = 10'(x0);
        seg_y0     = 10'(y0);
        seg_x1     = 10'(x1);
        seg_y1     = 10'(y1);
        seg_bright = 10'(b);
        seg_valid  = 1'b1;
        n = 0;
        while (seg_ready !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        compared++;
        if (n >= 200) begin
            mismatched++;
            $display("[TB] FAIL offer_timeout seg_ready=%b want 1", seg_ready);
        end
        step();
        seg_valid  = 1'b0;
        seg_x0     = 10'($urandom);
        seg_y0     = 10'($urandom);
        seg_x1     = 10'($urandom);
        seg_y1     = 10'($urandom);
        seg_bright = 10'($urandom);
    endtask

    // Offers a segment and returns once it is in the drawing state.
    task automatic sendSeg(input int x0, input int y0, input int x1, input int y1, input int b);
        offerSeg(x0, y0, x1, y1, b);
        step();
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        pixel_step = 1'b0;
        seg_valid  = 1'b0;
        step();
        step();
        reset = 1'b0;
        compared++;
        if ({seg_ready, busy} !== 2'b10) begin
            mismatched++;
            $display("[TB] FAIL reset_status got ready/busy=%b want 10", {seg_ready, busy});
        end
        compared++;
        if ({ch0frequenz, ch1frequenz, ch0amplitude, ch1amplitude} !== {BASE, BASE, 10'd0, 10'd0}) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs got %h %h %0d %0d want %h %h 0 0",
                     ch0frequenz, ch1frequenz, ch0amplitude, ch1amplitude, BASE, BASE);
        end
        lastX = 0;
        lastY = 0;
    endtask

    task automatic test_horizontal();
        logic [31:0] want0;
        sendSeg(0, 0, 3, 0, 512);
        for (int i = 0; i < 4; i++) begin
            pulse();
            want0 = BASE + 32'(i) * 32'h1000;
            compared++;
            if ({ch0frequenz, ch1frequenz, ch0amplitude, ch1amplitude} !== {want0, BASE, 10'd512, 10'd512}) begin
                mismatched++;
                $display("[TB] FAIL horiz_point%0d got %h %h %0d want %h %h 512", i,
                         ch0frequenz, ch1frequenz, ch0amplitude, want0, BASE);
            end
            compared++;
            if (seg_ready !== 1'(i == 3)) begin
                mismatched++;
                $display("[TB] FAIL horiz_ready%0d got %b want %b", i, seg_ready, (i == 3));
            end
        end
        pulse();
        compared++;
        if ({ch0frequenz, ch1frequenz, ch0amplitude, ch1amplitude} !== {32'h0800_3000, BASE, 10'd0, 10'd0}) begin
            mismatched++;
            $display("[TB] FAIL horiz_blank got %h %h %0d %0d want 08003000 %h 0 0",
                     ch0frequenz, ch1frequenz, ch0amplitude, ch1amplitude, BASE);
        end
        lastX = 3;
        lastY = 0;
    endtask

    task automatic test_steep();
        int px[4] = '{0, 0, 1, 1};
        int py[4] = '{0, 1, 2, 3};
        sendSeg(0, 0, 1, 3, 700);
        for (int i = 0; i < 4; i++) begin
            pulse();
            compared++;
            if ({ch0frequenz, ch1frequenz, ch0amplitude} !== {fw(px[i]), fw(py[i]), 10'd700}) begin
                mismatched++;
                $display("[TB] FAIL steep_point%0d got %h %h %0d want %h %h 700", i,
                         ch0frequenz, ch1frequenz, ch0amplitude, fw(px[i]), fw(py[i]));
            end
        end
        compared++;
        if (ch1frequenz !== 32'h0800_3000) begin
            mismatched++;
            $display("[TB] FAIL steep_final_ch1 got %h want 08003000", ch1frequenz);
        end
        lastX = 1;
        lastY = 3;
    endtask

    task automatic test_negative();
        sendSeg(3, 1, 0, 1, 300);
        for (int i = 0; i < 4; i++) begin
            pulse();
            compared++;
            if ({ch0frequenz, ch1frequenz, ch1amplitude} !== {fw(3 - i), 32'h0800_1000, 10'd300}) begin
                mismatched++;
                $display("[TB] FAIL neg_point%0d got %h %h %0d want %h 08001000 300", i,
                         ch0frequenz, ch1frequenz, ch1amplitude, fw(3 - i));
            end
        end
        lastX = 0;
        lastY = 1;
    endtask

    task automatic test_degenerate();
        sendSeg(5, 7, 5, 7, 1023);
        pulse();
        compared++;
        if ({ch0frequenz, ch1frequenz, ch0amplitude, ch1amplitude, seg_ready} !==
            {32'h0800_5000, 32'h0800_7000, 10'd1023, 10'd1023, 1'b1}) begin
            mismatched++;
            $display("[TB] FAIL degen_point got %h %h %0d %0d ready=%b want 08005000 08007000 1023 1023 1",
                     ch0frequenz, ch1frequenz, ch0amplitude, ch1amplitude, seg_ready);
        end
        pulse();
        compared++;
        if ({ch0frequenz, ch1frequenz, ch0amplitude, ch1amplitude} !==
            {32'h0800_5000, 32'h0800_7000, 10'd0, 10'd0}) begin
            mismatched++;
            $display("[TB] FAIL degen_blank got %h %h %0d %0d want 08005000 08007000 0 0",
                     ch0frequenz, ch1frequenz, ch0amplitude, ch1amplitude);
        end
        lastX = 5;
        lastY = 7;
    endtask

    // A step landing in LOAD is blank and must not consume the first point.
    task automatic test_blank_load();
        int x0, y0;
        x0 = $urandom_range(0, 1000);
        y0 = $urandom_range(0, 1000);
        clearPath();
        buildPath(x0, y0, x0 + 4, y0 + 2, 99);
        offerSeg(x0, y0, x0 + 4, y0 + 2, 99);
        compared++;
        if ({busy, seg_ready} !== 2'b10) begin
            mismatched++;
            $display("[TB] FAIL load_status got busy/ready=%b want 10", {busy, seg_ready});
        end
        pulse();
        compared++;
        if ({ch0frequenz, ch1frequenz, ch0amplitude, ch1amplitude} !== {fw(lastX), fw(lastY), 10'd0, 10'd0}) begin
            mismatched++;
            $display("[TB] FAIL load_blank got %h %h %0d %0d want %h %h 0 0",
                     ch0frequenz, ch1frequenz, ch0amplitude, ch1amplitude, fw(lastX), fw(lastY));
        end
        for (int k = 0; k < expX.size(); k++) begin
            pulse();
            compared++;
            if ({ch0frequenz, ch1frequenz, ch0amplitude} !== {fw(expX[k]), fw(expY[k]), 10'(expB[k])}) begin
                mismatched++;
                $display("[TB] FAIL load_point%0d got %h %h %0d want %h %h %0d", k,
                         ch0frequenz, ch1frequenz, ch0amplitude, fw(expX[k]), fw(expY[k]), expB[k]);
            end
        end
        lastX = expX[expX.size() - 1];
        lastY = expY[expY.size() - 1];
    endtask

    // Two segments queued behind a held seg_valid; steps every 20 clocks.
    task automatic test_back_to_back();
        int ax0, ay0, ax1, ay1, ab, bx0, by0, bx1, by1, bb;
        int cyc, popped, total, segIdx;
        logic fire, stepped;
        ax0 = $urandom_range(0, 1023);
        ay0 = $urandom_range(0, 1023);
        ax1 = clampC(ax0 + $urandom_range(0, 12) - 6);
        ay1 = clampC(ay0 + $urandom_range(0, 12) - 6);
        ab  = $urandom_range(1, 1023);
        bx0 = $urandom_range(0, 1023);
        by0 = $urandom_range(0, 1023);
        bx1 = clampC(bx0 + $urandom_range(0, 12) - 6);
        by1 = clampC(by0 + $urandom_range(0, 12) - 6);
        bb  = $urandom_range(1, 1023);
        clearPath();
        buildPath(ax0, ay0, ax1, ay1, ab);
        buildPath(bx0, by0, bx1, by1, bb);
        total = expX.size();
        seg_x0     = 10'(ax0);
        seg_y0     = 10'(ay0);
        seg_x1     = 10'(ax1);
        seg_y1     = 10'(ay1);
        seg_bright = 10'(ab);
        seg_valid  = 1'b1;
        segIdx = 0;
        popped = 0;
        cyc    = 0;
        while (popped < total && cyc < 3000) begin
            compared++;
            if (seg_ready !== ~busy) begin
                mismatched++;
                $display("[TB] FAIL b2b_ready_vs_busy cyc %0d got ready=%b busy=%b", cyc, seg_ready, busy);
            end
            fire       = seg_valid & seg_ready;
            pixel_step = ((cyc % 20) == 5);
            stepped    = pixel_step;
            step();
            pixel_step = 1'b0;
            if (fire) begin
                segIdx++;
                if (segIdx == 1) begin
                    seg_x0     = 10'(bx0);
                    seg_y0     = 10'(by0);
                    seg_x1     = 10'(bx1);
                    seg_y1     = 10'(by1);
                    seg_bright = 10'(bb);
                end else begin
                    seg_valid = 1'b0;
                end
            end
            if (stepped) begin
                compared++;
                if ({ch0frequenz, ch1frequenz, ch0amplitude, ch1amplitude} !==
                    {fw(expX[popped]), fw(expY[popped]), 10'(expB[popped]), 10'(expB[popped])}) begin
                    mismatched++;
                    $display("[TB] FAIL b2b_point%0d got %h %h %0d %0d want %h %h %0d", popped,
                             ch0frequenz, ch1frequenz, ch0amplitude, ch1amplitude,
                             fw(expX[popped]), fw(expY[popped]), expB[popped]);
                end
                popped++;
            end
            cyc++;
        end
        seg_valid = 1'b0;
        compared++;
        if (popped != total) begin
            mismatched++;
            $display("[TB] FAIL b2b_timeout got %0d points want %0d", popped, total);
        end
        lastX = expX[total - 1];
        lastY = expY[total - 1];
    endtask

    // Random short segments with random gaps between steps.
    task automatic test_random();
        int x0, y0, x1, y1, b, n, hold;
        for (int s = 0; s < 12; s++) begin
            x0 = $urandom_range(0, 1023);
            y0 = $urandom_range(0, 1023);
            x1 = clampC(x0 + $urandom_range(0, 30) - 15);
            y1 = clampC(y0 + $urandom_range(0, 30) - 15);
            b  = $urandom_range(1, 1023);
            clearPath();
            buildPath(x0, y0, x1, y1, b);
            n = expX.size();
            sendSeg(x0, y0, x1, y1, b);
            for (int k = 0; k < n; k++) begin
                pulse();
                compared++;
                if ({ch0frequenz, ch1frequenz, ch0amplitude, ch1amplitude} !==
                    {fw(expX[k]), fw(expY[k]), 10'(b), 10'(b)}) begin
                    mismatched++;
                    $display("[TB] FAIL rand_s%0d_p%0d got %h %h %0d %0d want %h %h %0d", s, k,
                             ch0frequenz, ch1frequenz, ch0amplitude, ch1amplitude,
                             fw(expX[k]), fw(expY[k]), b);
                end
                compared++;
                if (seg_ready !== 1'(k == n - 1)) begin
                    mismatched++;
                    $display("[TB] FAIL rand_ready_s%0d_p%0d got %b want %b", s, k, seg_ready, (k == n - 1));
                end
                hold = $urandom_range(0, 3);
                repeat (hold) step();
                compared++;
                if ({ch0frequenz, ch1frequenz, ch0amplitude} !== {fw(expX[k]), fw(expY[k]), 10'(b)}) begin
                    mismatched++;
                    $display("[TB] FAIL rand_hold_s%0d_p%0d got %h %h %0d want %h %h %0d", s, k,
                             ch0frequenz, ch1frequenz, ch0amplitude, fw(expX[k]), fw(expY[k]), b);
                end
            end
            lastX = expX[n - 1];
            lastY = expY[n - 1];
            if ($urandom_range(0, 1) == 1) begin
                pulse();
                compared++;
                if ({ch0frequenz, ch1frequenz, ch0amplitude, ch1amplitude} !== {fw(lastX), fw(lastY), 10'd0, 10'd0}) begin
                    mismatched++;
                    $display("[TB] FAIL rand_blank_s%0d got %h %h %0d %0d want %h %h 0 0", s,
                             ch0frequenz, ch1frequenz, ch0amplitude, ch1amplitude, fw(lastX), fw(lastY));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        sendSeg(0, 0, 9, 0, 300);
        for (int i = 0; i < 2; i++) begin
            pulse();
            compared++;
            if ({ch0frequenz, ch0amplitude} !== {fw(i), 10'd300}) begin
                mismatched++;
                $display("[TB] FAIL midrst_point%0d got %h %0d want %h 300", i, ch0frequenz, ch0amplitude, fw(i));
            end
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        compared++;
        if ({ch0amplitude, ch1amplitude, ch0frequenz, ch1frequenz, busy, seg_ready} !==
            {10'd0, 10'd0, BASE, BASE, 1'b0, 1'b1}) begin
            mismatched++;
            $display("[TB] FAIL midrst_state got %0d %0d %h %h busy=%b ready=%b want 0 0 %h %h 0 1",
                     ch0amplitude, ch1amplitude, ch0frequenz, ch1frequenz, busy, seg_ready, BASE, BASE);
        end
        for (int i = 0; i < 3; i++) begin
            pulse();
            compared++;
            if ({ch0frequenz, ch1frequenz, ch0amplitude, ch1amplitude} !== {BASE, BASE, 10'd0, 10'd0}) begin
                mismatched++;
                $display("[TB] FAIL midrst_blank%0d got %h %h %0d %0d want %h %h 0 0", i,
                         ch0frequenz, ch1frequenz, ch0amplitude, ch1amplitude, BASE, BASE);
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        pixel_step = 1'b0;
        seg_valid  = 1'b0;
        seg_x0     = 10'd0;
        seg_y0     = 10'd0;
        seg_x1     = 10'd0;
        seg_y1     = 10'd0;
        seg_bright = 10'd0;
        test_reset();
        test_horizontal();
        test_steep();
        test_negative();
        test_degenerate();
        test_blank_load();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/vector_line_stepper.md
Name: vector_line_stepper

Overview:
- Upstream feeder of the DDS serializer stage.
- Accepts line segments from the vector graphics unit and walks each one with Bresenham stepping, producing one beam position per pixel step.
- Each position is mapped to ch0/ch1 frequency words (X→ch0, Y→ch1) plus ch0/ch1 amplitudes.
- The serializer pulses pixel_step when its shift register is freshly loaded; this block must have the next point settled well before the next reload.

Parameters:
- FREQ_BASE, 32'h0800_0000, frequency word for coordinate 0.
- FREQ_SHIFT, 12, left shift applied to the 10-bit coordinate before adding FREQ_BASE.

Ports:
- clk  in  1  system clock (DDS Sync_clk domain).
- reset  in  1  synchronous, active-high reset.
- pixel_step  in  1  one-cycle pulse from the serializer: advance to next point.
- seg_valid  in  1  segment offered.
- seg_ready  out  1  segment can be accepted.
- seg_x0, seg_y0  in  10 each  start point.
- seg_x1, seg_y1  in  10 each  end point (inclusive).
- seg_bright  in  10  amplitude while drawing this segment.
- ch0frequenz  out  32  X frequency word.
- ch1frequenz  out  32  Y frequency word.
- ch0amplitude  out  10  X channel amplitude.
- ch1amplitude  out  10  Y channel amplitude.
- busy  out  1  high in LOAD or DRAW.

Behaviour:
- One clock (clk). Reset is synchronous and active-high, applied on the clk edge.
- States: IDLE, LOAD, DRAW.
- Reset values:
  - state=IDLE, seg_ready=1, busy=0.
  - ch0frequenz=ch1frequenz=FREQ_BASE; ch0amplitude=ch1amplitude=0.
  - Internal x=y=0.
- Handshake:
  - seg_ready = (state==IDLE), combinational from state.
  - Transfer occurs on a clk edge with seg_valid&seg_ready. Inputs are captured, then state→LOAD.
  - seg_valid without ready: no effect. Inputs are not required stable before transfer.
- LOAD (exactly 1 cycle), computes:
  - dx=|x1-x0|, dy=-|y1-y0|, sx=(x0<x1)?+1:-1, sy=(y0<y1)?+1:-1, err=dx+dy.
  - cur=(x0,y0).
  - Then state→DRAW.
- Arithmetic: dx, dy, err and e2 are signed 13-bit. Coordinates are 10-bit unsigned and never leave [min,max] of the segment endpoints.
- DRAW, on pixel_step:
  - Outputs are registered next edge (latency 1 clk) with ch0frequenz=FREQ_BASE+(x<<FREQ_SHIFT), ch1frequenz=FREQ_BASE+(y<<FREQ_SHIFT), 32-bit modulo, amplitudes=bright.
  - If cur==end: state→IDLE on the same edge, and seg_ready is high the next cycle.
  - Else advance with e2=2*err:
    - if e2>=dy: err+=dy, x+=sx.
    - if e2<=dx: err+=dx, y+=sy.
    - Both updates use the pre-update err.
- DRAW without pixel_step: hold everything.
- pixel_step in IDLE or LOAD: blank step. Amplitudes→0 on the next edge; frequency words hold their last value, so the beam parks. No point is consumed.
- Degenerate segment (start==end): exactly one point is emitted.
- Consecutive segments: the minimum gap is 2 clk (accept + LOAD), which is well inside one serializer frame. No blank is emitted unless pixel_step lands in IDLE or LOAD.
- Reset mid-DRAW: the segment is abandoned, reset values apply on the next edge, and no further points are emitted.
- Outputs change only on a pixel_step edge or a reset edge. They never change between steps.

Test Plan:
- Horizontal line: segment (0,0)->(3,0), bright=512, then 5 pulses → four points x=0,1,2,3, y=0; ch0frequenz=0x0800_0000, 0x0800_1000, 0x0800_2000, 0x0800_3000; amplitude 512; 5th pulse gives amplitude 0 with ch0frequenz held at 0x0800_3000; seg_ready high 1 clk after the 4th pulse.
- Steep line: (0,0)->(1,3), then 4 pulses → points (0,0),(0,1),(1,2),(1,3); ch1frequenz ends at 0x0800_3000.
- Negative direction: (3,1)->(0,1) → x=3,2,1,0 and y=1 for all points; ch1frequenz=0x0800_1000 throughout.
- Degenerate point (5,7), bright=1023, then 2 pulses → one point with ch0frequenz=0x0800_5000, ch1frequenz=0x0800_7000, amplitude 1023; then a blank step with amplitude 0.
- Back-to-back segments: seg_valid held high with two queued segments, pulses every 20 clk → no blank step between segments; seg_ready is high only in IDLE cycles.
- Reset mid-line: assert reset after the 2nd point of (0,0)->(9,0) → next edge gives amplitude 0, ch0frequenz=0x0800_0000, busy=0, seg_ready=1; further pulses give blank steps only.
